// File: rtl/procyon_mdu.sv
// procyon_mdu: iterative RV32M multiply/divide functional unit.
// Takes one op from the reservation station and computes one bit per cycle.
// Multiplies use shift-add and divides use restoring shift-subtract. Each takes
// W iterations. Divides by zero and signed-overflow divides finish in one cycle.
// The unit holds o_fu_stall until its one-cycle CDB broadcast is done.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   i_flush          abort any in-flight op; an op offered in the same cycle is ignored
//   i_fu_valid       issued op present on i_fu_* (sampled only while idle)
//   i_fu_insn        instruction word; funct3 = insn[14:12] selects the op
//   i_fu_src_a/b     rs1 / rs2 values
//   i_fu_tag         destination ROB tag
//   o_fu_stall       unit busy
//   o_cdb_en         one-cycle result broadcast
//   o_cdb_data/tag   result value and ROB tag, held until the next broadcast
module procyon_mdu #(
    parameter int unsigned OPTN_DATA_WIDTH    = 32,
    parameter int unsigned OPTN_ROB_IDX_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_fu_valid,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_fu_insn,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_fu_src_a,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_fu_src_b,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_fu_tag,
    output logic                          o_fu_stall,
    output logic                          o_cdb_en,
    output logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data,
    output logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag
);

    localparam int unsigned W  = OPTN_DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 count_q;
    logic [2:0]                    f3_q;
    logic [OPTN_ROB_IDX_WIDTH-1:0] tag_q;
    logic                          neg_q;
    // opa_q: multiplicand (shifted left each step) / divisor in the low W bits
    // opb_q: multiplier (shifted right) / dividend shifting out, quotient shifting in
    // acc_q: product accumulator / partial remainder in the low W bits
    logic [2*W-1:0]                opa_q;
    logic [W-1:0]                  opb_q;
    logic [2*W-1:0]                acc_q;
    logic                          cdb_en_q;
    logic [W-1:0]                  cdb_data_q;
    logic [OPTN_ROB_IDX_WIDTH-1:0] cdb_tag_q;

    logic unused_insn;
    assign unused_insn = ^{i_fu_insn[W-1:15], i_fu_insn[11:0]};

    // ---------------- Accept-time decode ----------------
    logic [2:0]   f3_in;
    logic         is_div_in, sign_a, sign_b, neg_in;
    logic         div_zero, div_ovf, special;
    logic [W-1:0] mag_a, mag_b, special_res;

    assign f3_in     = i_fu_insn[14:12];
    assign is_div_in = f3_in[2];

    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (f3_in)
            3'b001, 3'b100, 3'b110: begin
                sign_a = i_fu_src_a[W-1];
                sign_b = i_fu_src_b[W-1];
            end
            3'b010:  sign_a = i_fu_src_a[W-1];
            default: ;
        endcase
    end

    assign mag_a  = sign_a ? (~i_fu_src_a + 1'b1) : i_fu_src_a;
    assign mag_b  = sign_b ? (~i_fu_src_b + 1'b1) : i_fu_src_b;
    // A remainder takes the dividend's sign. Every other result takes the XOR of both signs.
    assign neg_in = (f3_in == 3'b110) ? sign_a : (sign_a ^ sign_b);

    assign div_zero = is_div_in && (i_fu_src_b == '0);
    assign div_ovf  = is_div_in && !f3_in[0] && (i_fu_src_a == {1'b1, {(W-1){1'b0}}})
                      && (i_fu_src_b == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        if (div_zero) special_res = f3_in[1] ? i_fu_src_a : '1;
        else          special_res = f3_in[1] ? '0 : i_fu_src_a;
    end

    // ---------------- Iteration datapath ----------------
    logic [2*W-1:0] mul_acc_nxt, prod;
    logic [W:0]     div_trial, div_diff;
    logic           div_ge;
    logic [W-1:0]   rem_nxt, quo_nxt, rem_fin, quo_fin, mul_res, div_res;
    logic           last_iter;

    assign mul_acc_nxt = acc_q + (opb_q[0] ? opa_q : '0);

    assign div_trial = {acc_q[W-1:0], opb_q[W-1]};
    assign div_diff  = div_trial - {1'b0, opa_q[W-1:0]};
    assign div_ge    = ~div_diff[W];
    assign rem_nxt   = div_ge ? div_diff[W-1:0] : div_trial[W-1:0];
    assign quo_nxt   = {opb_q[W-2:0], div_ge};

    assign prod    = neg_q ? (~mul_acc_nxt + 1'b1) : mul_acc_nxt;
    assign mul_res = (f3_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];

    assign rem_fin = neg_q ? (~rem_nxt + 1'b1) : rem_nxt;
    assign quo_fin = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    assign div_res = f3_q[1] ? rem_fin : quo_fin;

    assign last_iter = (count_q == CW'(W - 1));

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (i_fu_valid) begin
                    if (special)        state_d = StDone;
                    else if (is_div_in) state_d = StDiv;
                    else                state_d = StMul;
                end
            end
            StMul, StDiv: if (last_iter) state_d = StDone;
            StDone:       state_d = StIdle;
            default:      state_d = StIdle;
        endcase
        if (i_flush) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            f3_q       <= '0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            cdb_en_q   <= 1'b0;
            cdb_data_q <= '0;
            cdb_tag_q  <= '0;
        end else begin
            state_q  <= state_d;
            cdb_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_fu_valid && !i_flush) begin
                        f3_q    <= f3_in;
                        tag_q   <= i_fu_tag;
                        neg_q   <= neg_in;
                        count_q <= '0;
                        acc_q   <= '0;
                        opa_q   <= {{W{1'b0}}, is_div_in ? mag_b : mag_a};
                        opb_q   <= is_div_in ? mag_a : mag_b;
                        if (special) begin
                            cdb_en_q   <= 1'b1;
                            cdb_data_q <= special_res;
                            cdb_tag_q  <= i_fu_tag;
                        end
                    end
                end
                StMul: begin
                    acc_q   <= mul_acc_nxt;
                    opa_q   <= opa_q << 1;
                    opb_q   <= opb_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (last_iter && !i_flush) begin
                        cdb_en_q   <= 1'b1;
                        cdb_data_q <= mul_res;
                        cdb_tag_q  <= tag_q;
                    end
                end
                StDiv: begin
                    acc_q   <= {{W{1'b0}}, rem_nxt};
                    opb_q   <= quo_nxt;
                    count_q <= count_q + CW'(1);
                    if (last_iter && !i_flush) begin
                        cdb_en_q   <= 1'b1;
                        cdb_data_q <= div_res;
                        cdb_tag_q  <= tag_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_fu_stall = (state_q != StIdle);
    assign o_cdb_en   = cdb_en_q;
    assign o_cdb_data = cdb_data_q;
    assign o_cdb_tag  = cdb_tag_q;

endmodule
